// File: rtl/jt51_mix_pkg.sv
// Shared widths, connection-algorithm codes and saturation limits for the
// jt51 channel accumulator / stereo mixer.
package jt51_mix_pkg;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned STAGES  = 8;
   localparam int unsigned OP_W    = 14;
   localparam int unsigned NOISE_W = 10;
   localparam int unsigned MAN_W   = 10;
   localparam int unsigned EXP_W   = 3;

   localparam logic [2:0] CON_ALG4 = 3'd4;
   localparam logic [2:0] CON_ALG5 = 3'd5;
   localparam logic [2:0] CON_ALG6 = 3'd6;
   localparam logic [2:0] CON_ALG7 = 3'd7;

   localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
   localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

   typedef struct packed {
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } dac_t;

endpackage

// File: rtl/jt51_mix_fmt.sv
// DAC-format round trip: linear -> (10-bit mantissa, 3-bit exponent) -> linear,
// truncating the bits the DAC would drop.
module jt51_mix_fmt
   import jt51_mix_pkg::*;
(
   input  logic [WIDTH-1:0] lin_i,
   output logic [WIDTH-1:0] lin_c
);

   // Smallest exponent whose mantissa still carries the whole magnitude.
   function automatic dac_t lin2exp(input logic [WIDTH-1:0] lin);
      dac_t             r;
      logic             found;
      logic [WIDTH-1:0] hi;
      r.exp = EXP_W'(7);
      r.man = lin[WIDTH-1:WIDTH-MAN_W];
      found = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         hi = WIDTH'($signed(lin) >>> (8 + e));
         if (!found && (hi == '0 || hi == '1)) begin
            found = 1'b1;
            r.exp = EXP_W'(e);
            r.man = MAN_W'(lin >> (e - 1));
         end
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] exp2lin(input dac_t d);
      logic [WIDTH-1:0] ext;
      ext = {{(WIDTH-MAN_W){d.man[MAN_W-1]}}, d.man};
      return (d.exp == '0) ? '0 : ext << (d.exp - 3'd1);
   endfunction

   dac_t dac;

   always_comb begin
      dac   = lin2exp(lin_i);
      lin_c = exp2lin(dac);
   end

endmodule

// File: rtl/jt51_mix_sh.sv
// Generic shift-register delay line with asynchronous clear; the output is
// the value pushed STAGES clocks earlier.
module jt51_mix_sh #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] drop_o
);

   logic [WIDTH-1:0] bits_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) bits_q[i] <= '0;
      end else begin
         bits_q[0] <= din_i;
         for (int i = 1; i < STAGES; i++) bits_q[i] <= bits_q[i-1];
      end
   end

   assign drop_o = bits_q[STAGES-1];

endmodule

// File: rtl/jt51_mix_acc.sv
// Per-channel operator accumulator over an 8-slot delay line, followed by the
// left/right channel mixer and DAC-quantised copies of the mixed totals.
module jt51_mix_acc
   import jt51_mix_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      m1_enters,
   input  logic                      m2_enters,
   input  logic                      c1_enters,
   input  logic                      c2_enters,
   input  logic                      op31_acc,
   input  logic [1:0]                rl_I,
   input  logic [2:0]                con_I,
   input  logic signed [OP_W-1:0]    op_out,
   input  logic                      ne,
   input  logic signed [NOISE_W-1:0] noise,
   output logic signed [WIDTH-1:0]   left,
   output logic signed [WIDTH-1:0]   right,
   output logic signed [WIDTH-1:0]   xleft,
   output logic signed [WIDTH-1:0]   xright
);

   logic [WIDTH-1:0] op_val_c;
   logic             sum_en_c;
   logic [WIDTH-1:0] total;
   logic [WIDTH:0]   sum_wide_c;
   logic [WIDTH-1:0] opsum_c;

   logic [WIDTH-1:0] pre_left_q,  pre_left_d;
   logic [WIDTH-1:0] pre_right_q, pre_right_d;
   logic [WIDTH-1:0] xleft_q,     xleft_d;
   logic [WIDTH-1:0] xright_q,    xright_d;
   logic             sum_all_q,   sum_all_d;
   logic [WIDTH-1:0] left_term_c, right_term_c;

   // The noise generator replaces operator 31 when enabled.
   always_comb begin
      if (ne && op31_acc)
         op_val_c = {{(WIDTH-NOISE_W-4){noise[NOISE_W-1]}}, noise, 4'b0000};
      else
         op_val_c = {{(WIDTH-OP_W){op_out[OP_W-1]}}, op_out};
   end

   always_comb begin
      sum_en_c = c2_enters;
      case (con_I)
         CON_ALG4: sum_en_c = m2_enters | c2_enters;
         CON_ALG5,
         CON_ALG6: sum_en_c = ~m1_enters;
         CON_ALG7: sum_en_c = 1'b1;
         default:  sum_en_c = c2_enters;
      endcase
   end

   // C2 restarts a channel; otherwise add with saturation or recirculate.
   always_comb begin
      sum_wide_c = {op_val_c[WIDTH-1], op_val_c} + {total[WIDTH-1], total};
      opsum_c    = total;
      if (c2_enters) begin
         opsum_c = sum_en_c ? op_val_c : '0;
      end else if (sum_en_c) begin
         if (sum_wide_c[WIDTH] != sum_wide_c[WIDTH-1])
            opsum_c = sum_wide_c[WIDTH] ? SAT_NEG : SAT_POS;
         else
            opsum_c = sum_wide_c[WIDTH-1:0];
      end
   end

   jt51_mix_sh #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) u_sh (
      .clk    (clk),
      .rst_n  (rst),
      .din_i  (opsum_c),
      .drop_o (total)
   );

   // Mixer: C1 latching wins over the C2 set of sum_all in a shared cycle.
   always_comb begin
      pre_left_d   = pre_left_q;
      pre_right_d  = pre_right_q;
      xleft_d      = xleft_q;
      xright_d     = xright_q;
      sum_all_d    = sum_all_q;
      left_term_c  = rl_I[0] ? total : '0;
      right_term_c = rl_I[1] ? total : '0;
      if (c2_enters) begin
         pre_left_d  = sum_all_q ? pre_left_q  + left_term_c  : left_term_c;
         pre_right_d = sum_all_q ? pre_right_q + right_term_c : right_term_c;
         sum_all_d   = 1'b1;
      end
      if (c1_enters) begin
         xleft_d   = pre_left_q;
         xright_d  = pre_right_q;
         sum_all_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_left_q  <= '0;
         pre_right_q <= '0;
         xleft_q     <= '0;
         xright_q    <= '0;
         sum_all_q   <= 1'b0;
      end else begin
         pre_left_q  <= pre_left_d;
         pre_right_q <= pre_right_d;
         xleft_q     <= xleft_d;
         xright_q    <= xright_d;
         sum_all_q   <= sum_all_d;
      end
   end

   assign xleft  = xleft_q;
   assign xright = xright_q;

   jt51_mix_fmt u_fmt_l (
      .lin_i (xleft_q),
      .lin_c (left)
   );

   jt51_mix_fmt u_fmt_r (
      .lin_i (xright_q),
      .lin_c (right)
   );

endmodule

// File: tb/tb_jt51_mix_acc.sv
// Randomised and directed bench for jt51_mix_acc against a queue-based model.
module tb_jt51_mix_acc;

   logic               clk       = 1'b0;
   logic               rst       = 1'b0;
   logic               m1_enters = 1'b0;
   logic               m2_enters = 1'b0;
   logic               c1_enters = 1'b0;
   logic               c2_enters = 1'b0;
   logic               op31_acc  = 1'b0;
   logic [1:0]         rl_I      = 2'b00;
   logic [2:0]         con_I     = 3'd0;
   logic signed [13:0] op_out    = '0;
   logic               ne        = 1'b0;
   logic signed [9:0]  noise     = '0;
   logic signed [15:0] left, right, xleft, xright;

   always #5 clk = ~clk;

   jt51_mix_acc dut (
      .clk       (clk),
      .rst       (rst),
      .m1_enters (m1_enters),
      .m2_enters (m2_enters),
      .c1_enters (c1_enters),
      .c2_enters (c2_enters),
      .op31_acc  (op31_acc),
      .rl_I      (rl_I),
      .con_I     (con_I),
      .op_out    (op_out),
      .ne        (ne),
      .noise     (noise),
      .left      (left),
      .right     (right),
      .xleft     (xleft),
      .xright    (xright)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: channel sums as a FIFO of the last eight pushes.
   int dq[$];
   int m_pl, m_pr, m_xl, m_xr;
   bit m_sa;

   int r_op[8];
   int r_rl[8];
   int r_nch   = -1;
   int r_noise = 0;

   function automatic int wrap16(input int v);
      int r;
      r = v & 32'h0000_FFFF;
      if (r >= 32768) r = r - 65536;
      return r;
   endfunction

   function automatic int floordiv(input int v, input int d);
      if (v >= 0) return v / d;
      return -((-v + d - 1) / d);
   endfunction

   // Pick the finest step that keeps the value in a 10-bit signed mantissa.
   function automatic int quant(input int v);
      int e;
      int step;
      bit found;
      e = 7;
      found = 0;
      for (int k = 1; k <= 7; k++) begin
         if (!found && v >= -(1 << (8 + k)) && v < (1 << (8 + k))) begin
            e = k;
            found = 1;
         end
      end
      step = 1 << (e - 1);
      return floordiv(v, step) * step;
   endfunction

   task automatic model_reset();
      dq.delete();
      for (int i = 0; i < 8; i++) dq.push_back(0);
      m_pl = 0; m_pr = 0; m_xl = 0; m_xr = 0; m_sa = 0;
   endtask

   task automatic model_step();
      int  opv, total, push, s, gl, gr;
      bit  en;
      int  npl, npr, nxl, nxr;
      bit  nsa;
      if (!rst) begin
         model_reset();
         return;
      end
      opv = (ne && op31_acc) ? int'(noise) * 16 : int'(op_out);
      if (con_I <= 3)      en = c2_enters;
      else if (con_I == 4) en = m2_enters || c2_enters;
      else if (con_I <= 6) en = !m1_enters;
      else                 en = 1;
      total = dq[0];
      if (c2_enters)   push = en ? opv : 0;
      else if (en) begin
         s = opv + total;
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
         push = s;
      end else         push = total;
      void'(dq.pop_front());
      dq.push_back(push);
      npl = m_pl; npr = m_pr; nxl = m_xl; nxr = m_xr; nsa = m_sa;
      gl = rl_I[0] ? total : 0;
      gr = rl_I[1] ? total : 0;
      if (c2_enters) begin
         npl = m_sa ? wrap16(m_pl + gl) : gl;
         npr = m_sa ? wrap16(m_pr + gr) : gr;
         nsa = 1;
      end
      if (c1_enters) begin
         nxl = m_pl; nxr = m_pr; nsa = 0;
      end
      m_pl = npl; m_pr = npr; m_xl = nxl; m_xr = nxr; m_sa = nsa;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("xleft",  int'(xleft),  m_xl);
      check("xright", int'(xright), m_xr);
      check("left",   int'(left),   quant(m_xl));
      check("right",  int'(right),  quant(m_xr));
   endtask

   // Inputs are set just after a falling edge; model and DUT advance together.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic do_round(input bit m1, input bit m2, input bit c1, input bit c2,
                           input logic [2:0] con);
      for (int ch = 0; ch < 8; ch++) begin
         m1_enters = m1; m2_enters = m2; c1_enters = c1; c2_enters = c2;
         con_I     = con;
         rl_I      = 2'(r_rl[ch]);
         op_out    = 14'(r_op[ch]);
         ne        = (ch == r_nch);
         op31_acc  = (ch == r_nch);
         noise     = 10'(r_noise);
         cycle();
      end
   endtask

   task automatic set_all(input int op, input int rl);
      for (int i = 0; i < 8; i++) begin
         r_op[i] = op;
         r_rl[i] = rl;
      end
      r_nch = -1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_xleft",  int'(xleft),  0);
      check("rst_xright", int'(xright), 0);
      check("rst_left",   int'(left),   0);
      check("rst_right",  int'(right),  0);
      @(negedge clk);
      cycle();
      rst = 1'b1;
   endtask

   // Load channel sums with M1-only rounds, mix with a C2 round, latch with C1.
   task automatic lml(input int n_load, input string name,
                      input int exl, input int exr, input int el, input int er);
      for (int n = 0; n < n_load; n++) do_round(1, 0, 0, 0, 3'd7);
      for (int i = 0; i < 8; i++) r_op[i] = 0;
      r_nch = -1;
      do_round(0, 0, 0, 1, 3'd7);
      do_round(0, 0, 1, 0, 3'd7);
      check({name, "_xleft"},  int'(xleft),  exl);
      check({name, "_xright"}, int'(xright), exr);
      check({name, "_left"},   int'(left),   el);
      check({name, "_right"},  int'(right),  er);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b1;

      // Algorithm 7: four slots of 1000 on channel 0 settle to 4000.
      do_reset();
      set_all(0, 3);
      r_op[0] = 1000;
      for (int f = 0; f < 3; f++) begin
         do_round(1, 0, 0, 0, 3'd7);
         do_round(0, 1, 0, 0, 3'd7);
         do_round(0, 0, 1, 0, 3'd7);
         do_round(0, 0, 0, 1, 3'd7);
      end
      check("alg7_xleft",  int'(xleft),  4000);
      check("alg7_xright", int'(xright), 4000);
      check("alg7_left",   int'(left),   4000);

      // Mid-run reset must empty the delay line.
      do_reset();
      set_all(0, 3);
      lml(0, "cleared", 0, 0, 0, 0);

      do_reset();
      set_all(0, 3);
      r_op[0] = 8191;
      lml(8, "satpos", 32767, 32767, 32704, 32704);

      do_reset();
      set_all(0, 3);
      r_op[0] = -8192;
      lml(8, "satneg", -32768, -32768, -32768, -32768);

      do_reset();
      set_all(0, 0);
      r_op[0] = 500;  r_rl[0] = 1;
      r_op[1] = -300; r_rl[1] = 2;
      lml(1, "route", 500, -300, 500, -300);

      do_reset();
      set_all(0, 3);
      r_op[0] = 123; r_nch = 0; r_noise = -5;
      lml(1, "noise", -80, -80, -80, -80);

      do_reset();
      set_all(0, 1);
      r_op[0] = 300;
      lml(1, "conv300", 300, 0, 300, 0);

      do_reset();
      set_all(0, 1);
      r_op[0] = 1234;
      lml(1, "conv1234", 1234, 0, 1232, 0);

      // Structured frames with random algorithms, routing and operator values.
      do_reset();
      for (int f = 0; f < 16; f++) begin
         logic [2:0] con;
         con = 3'($urandom_range(0, 7));
         for (int rd = 0; rd < 4; rd++) begin
            for (int i = 0; i < 8; i++) begin
               r_op[i] = int'(14'($urandom)) - ((($urandom & 1) != 0) ? 0 : 0);
               r_op[i] = (r_op[i] >= 8192) ? r_op[i] - 16384 : r_op[i];
               r_rl[i] = int'($urandom_range(0, 3));
            end
            r_nch   = int'($urandom_range(0, 15));
            r_noise = int'($urandom_range(0, 1023)) - 512;
            do_round(rd == 0, rd == 1, rd == 2, rd == 3, con);
         end
      end

      // Unstructured random slot flags, including C1/C2 collisions and resets.
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 399) != 0);
         m1_enters = ($urandom_range(0, 3) == 0);
         m2_enters = ($urandom_range(0, 3) == 0);
         c1_enters = ($urandom_range(0, 3) == 0);
         c2_enters = ($urandom_range(0, 3) == 0);
         op31_acc  = ($urandom_range(0, 3) == 0);
         ne        = ($urandom_range(0, 1) == 0);
         rl_I      = 2'($urandom_range(0, 3));
         con_I     = 3'($urandom_range(0, 7));
         op_out    = 14'($urandom);
         noise     = 10'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
